decode_stage_p: RTL and testbench
=================================

Name: decode_stage_p

Overview:
Parametrised ID stage plus ID/EX pipeline register for the 16-bit pipelined core. It integrates a bypassing register file, immediate generation and write-register selection. It adds internal load-use hazard detection with bubble insertion, a downstream stall (hold), a branch flush, a valid bit per stage, and a sticky error flag. It sits between the IF/ID register and the execute stage, and receives writeback from the MEM/WB register.

Parameters:
DATA_W, 16, datapath and instruction width; must be ≥ 16.
NREG, 8, number of architectural registers; power of 2, 2..32.
AW, $clog2(NREG), register address width (derived).
CTRL_W, 15, width of the opaque control bundle passed through (ALUOp, ALUF, ALUSrc, Branch, Dump, MemtoReg, …).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
instr_IFID  in  DATA_W  instruction from IF/ID
PC2_IFID  in  DATA_W  PC+2 from IF/ID
valid_IFID  in  1  IF/ID holds a real instruction
halt_IFID  in  1  halt marker
ctrl_in  in  CTRL_W  decoded pass-through control bundle
RegDst  in  2  00 rt=[7:5], 01 rd=[4:2], 10 rs=[10:8], 11 reg NREG-1
size  in  2  imm size: 00 5b, 01 8b, 10 11b, 11 illegal
zeroEx  in  1  1 = zero-extend, 0 = sign-extend
RegWrite, MemWrite, MemRead  in  1 each  decoded enables
use_rs, use_rt  in  1 each  instruction reads [10:8] / [7:5]
stall_in  in  1  downstream not ready; hold ID/EX
flush_in  in  1  taken branch resolved; squash
RegWrite_MEMWB  in  1  writeback enable
WrR_MEMWB  in  AW  writeback address
writeData  in  DATA_W  writeback data
stall_out  out  1  combinational; IF/PC must hold this cycle
PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX  out  DATA_W each  registered
ctrl_IDEX  out  CTRL_W  registered control bundle
Rd2Addr_IDEX, WrR_IDEX  out  AW each  registered
RegWrite_IDEX, MemWrite_IDEX, MemRead_IDEX, halt_IDEX, valid_IDEX  out  1 each  registered
err  out  1  sticky, registered

Behaviour:
- Reset: every ID/EX output is 0, err = 0, and all register-file entries are 0. Reset overrides everything in the same edge.
- Register file reads rs = instr[10:8] and rt = instr[7:5]. Address bits are zero-extended when AW > 3 and truncated to AW when AW < 3.
- Write-first bypass: if RegWrite_MEMWB and WrR_MEMWB equals the read address, the read returns writeData in the same cycle. The file write itself occurs at the edge.
- Imm for size 00/01/10 is instr[4:0], [7:0] or [10:0], sign- or zero-extended to DATA_W. size 11 gives Imm = 0.
- WrR is selected from RegDst as listed in Ports.
- Load-use hazard: stall_out = valid_IFID & MemRead_IDEX & valid_IDEX & ((use_rs & rs == WrR_IDEX) | (use_rt & rt == WrR_IDEX)) & ~flush_in.
- Per-edge priority, highest first:
  1. rst
  2. flush_in: bubble
  3. stall_in: all ID/EX registers hold, and stall_out is forced to 0
  4. stall_out: bubble
  5. normal load
- Bubble: valid, RegWrite, MemWrite, MemRead and halt are all 0. Data and ctrl fields load normally but are don't-care.
- A normal load with valid_IFID = 0 behaves identically to a bubble.
- Latency: one cycle from IF/ID to ID/EX. A load-use hazard costs exactly one bubble; the next cycle compares against the bubble (valid_IDEX = 0), so the stall releases.
- err: set on the edge where a normal load captures valid_IFID & size == 11 & ctrl ALUSrc. It is cleared only by rst.
- Reset mid-stall or mid-flush: rst wins, and the stage restarts empty.

Decomposition:
- Package decode_pkg holds:
  - RegDst codes REGDST_RT/RD/RS/R7
  - size codes IMM5/IMM8/IMM11/IMM_BAD
  - CTRL_W default
  - bit index of ALUSrc within ctrl
- One sub-module, rf_bypass: NREG×DATA_W, two read ports, one write port, synchronous reset, write-first bypass.
- Hazard detection, immediate generation and the pipeline register live in decode_stage_p.

Test Plan:
- Writeback bypass:
  - Stimulus: write R3 = 0xBEEF via WB while decoding an instruction with rs = 3.
  - Response: Rd1_IDEX = 0xBEEF next cycle, not the old 0x0000.
- Immediate generation:
  - size = 00, zeroEx = 0, instr[4:0] = 5'b10110 gives Imm_IDEX = 0xFFF6.
  - zeroEx = 1 gives 0x0016.
  - size = 10 with instr[10:0] = 0x400 gives 0xFC00.
- Load-use hazard:
  - Stimulus: load to R2 in ID/EX (MemRead_IDEX = 1, WrR_IDEX = 2), then an instruction with rt = 2 and use_rt = 1.
  - Response: stall_out = 1 for exactly one cycle and one bubble (valid_IDEX = 0, RegWrite_IDEX = 0). The instruction issues the following cycle.
- Flush beats stall:
  - Stimulus: flush_in = 1 together with stall_in = 1 and a hazard.
  - Response: ID/EX becomes a bubble and stall_out = 0.
- Downstream hold:
  - Stimulus: stall_in = 1 for 3 cycles while IF/ID inputs change.
  - Response: all ID/EX outputs hold their prior values.
- Error and reset:
  - Stimulus: size = 11, ALUSrc = 1, valid instruction.
  - Response: Imm_IDEX = 0 and err = 1, staying 1 after further clean instructions. rst then gives err = 0 and all outputs 0.
- Parameter sweep: repeat the bypass and hazard tests at NREG = 16 and DATA_W = 32.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings for the decode stage.
//   - RegDst codes selecting the destination register field
//   - immediate size codes
//   - default width of the opaque control bundle and the ALUSrc bit position
package decode_pkg;

    // Destination register select (RegDst input)
    localparam logic [1:0] REGDST_RT = 2'b00;  // instr[7:5]
    localparam logic [1:0] REGDST_RD = 2'b01;  // instr[4:2]
    localparam logic [1:0] REGDST_RS = 2'b10;  // instr[10:8]
    localparam logic [1:0] REGDST_R7 = 2'b11;  // highest register (NREG-1)

    // Immediate size (size input)
    localparam logic [1:0] IMM5    = 2'b00;
    localparam logic [1:0] IMM8    = 2'b01;
    localparam logic [1:0] IMM11   = 2'b10;
    localparam logic [1:0] IMM_BAD = 2'b11;

    // Control bundle
    localparam int CTRL_W_DEFAULT = 15;
    localparam int ALUSRC_BIT     = 4;

endpackage

// File: rtl/rf_bypass.sv
// rf_bypass: NREG x DATA_W register file, two combinational read ports and
// one write port with write-first bypass.
//   clk, rst            : clock, synchronous active-high reset (clears all entries)
//   rd1_addr, rd2_addr  : read addresses
//   rd1_data, rd2_data  : read data (bypassed from wr_data on address match)
//   we, wr_addr, wr_data: write port, written at the rising edge
module rf_bypass #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd1_addr,
    input  logic [AW-1:0]     rd2_addr,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A write in flight is visible to readers in the same cycle.
    assign rd1_data = (we && (wr_addr == rd1_addr)) ? wr_data : regs[rd1_addr];
    assign rd2_data = (we && (wr_addr == rd2_addr)) ? wr_data : regs[rd2_addr];

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode stage plus ID/EX pipeline register.
//   Inputs : IF/ID instruction, PC+2, valid, halt; decoded controls (ctrl_in,
//            RegDst, size, zeroEx, RegWrite/MemWrite/MemRead, use_rs/use_rt);
//            stall_in (downstream hold), flush_in (branch squash);
//            MEM/WB writeback (RegWrite_MEMWB, WrR_MEMWB, writeData).
//   Outputs: stall_out (combinational load-use stall for IF/PC), registered
//            ID/EX fields (*_IDEX) and the sticky err flag.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = $clog2(NREG),
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_IFID,
    input  logic [DATA_W-1:0] PC2_IFID,
    input  logic              valid_IFID,
    input  logic              halt_IFID,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [1:0]        RegDst,
    input  logic [1:0]        size,
    input  logic              zeroEx,
    input  logic              RegWrite,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              RegWrite_MEMWB,
    input  logic [AW-1:0]     WrR_MEMWB,
    input  logic [DATA_W-1:0] writeData,
    output logic              stall_out,
    output logic [DATA_W-1:0] PC2_IDEX,
    output logic [DATA_W-1:0] Rd1_IDEX,
    output logic [DATA_W-1:0] Rd2_IDEX,
    output logic [DATA_W-1:0] Imm_IDEX,
    output logic [CTRL_W-1:0] ctrl_IDEX,
    output logic [AW-1:0]     Rd2Addr_IDEX,
    output logic [AW-1:0]     WrR_IDEX,
    output logic              RegWrite_IDEX,
    output logic              MemWrite_IDEX,
    output logic              MemRead_IDEX,
    output logic              halt_IDEX,
    output logic              valid_IDEX,
    output logic              err
);

    // 3-bit instruction register fields resized to AW (zero-extend or truncate).
    function automatic logic [AW-1:0] reg_field(input logic [2:0] f);
        logic [AW+2:0] wide;
        wide = {{AW{1'b0}}, f};
        return wide[AW-1:0];
    endfunction

    logic [AW-1:0]     rs, rt, rd, wr_sel;
    logic [DATA_W-1:0] imm, rd1, rd2;
    logic              hazard, load_valid;
    logic              unused_instr_hi;

    assign rs = reg_field(instr_IFID[10:8]);
    assign rt = reg_field(instr_IFID[7:5]);
    assign rd = reg_field(instr_IFID[4:2]);
    assign unused_instr_hi = ^instr_IFID[DATA_W-1:11];

    rf_bypass #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd1_addr (rs),
        .rd2_addr (rt),
        .we       (RegWrite_MEMWB),
        .wr_addr  (WrR_MEMWB),
        .wr_data  (writeData),
        .rd1_data (rd1),
        .rd2_data (rd2)
    );

    always_comb begin
        imm = '0;
        case (size)
            IMM5:    imm = {{(DATA_W-5){~zeroEx & instr_IFID[4]}},   instr_IFID[4:0]};
            IMM8:    imm = {{(DATA_W-8){~zeroEx & instr_IFID[7]}},   instr_IFID[7:0]};
            IMM11:   imm = {{(DATA_W-11){~zeroEx & instr_IFID[10]}}, instr_IFID[10:0]};
            default: imm = '0;  // IMM_BAD
        endcase
    end

    always_comb begin
        wr_sel = '1;  // REGDST_R7: NREG-1 is all ones for a power-of-two file
        case (RegDst)
            REGDST_RT: wr_sel = rt;
            REGDST_RD: wr_sel = rd;
            REGDST_RS: wr_sel = rs;
            default:   wr_sel = '1;
        endcase
    end

    // Stall handshake: stall_in high means EX cannot accept, so ID/EX holds and
    // this stage raises no stall of its own (the whole front end is already
    // frozen). stall_out high means IF/PC must hold this cycle while ID/EX
    // takes a bubble. flush_in overrides both: the IF/ID contents are wrong-path.
    assign hazard = valid_IFID & MemRead_IDEX & valid_IDEX &
                    ((use_rs & (rs == WrR_IDEX)) | (use_rt & (rt == WrR_IDEX)));
    assign stall_out  = hazard & ~flush_in & ~stall_in;
    assign load_valid = valid_IFID & ~flush_in & ~stall_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            PC2_IDEX      <= '0;
            Rd1_IDEX      <= '0;
            Rd2_IDEX      <= '0;
            Imm_IDEX      <= '0;
            ctrl_IDEX     <= '0;
            Rd2Addr_IDEX  <= '0;
            WrR_IDEX      <= '0;
            RegWrite_IDEX <= 1'b0;
            MemWrite_IDEX <= 1'b0;
            MemRead_IDEX  <= 1'b0;
            halt_IDEX     <= 1'b0;
            valid_IDEX    <= 1'b0;
            err           <= 1'b0;
        end else if (flush_in || !stall_in) begin
            // Data fields always load; a bubble is made only by the qualifiers.
            PC2_IDEX      <= PC2_IFID;
            Rd1_IDEX      <= rd1;
            Rd2_IDEX      <= rd2;
            Imm_IDEX      <= imm;
            ctrl_IDEX     <= ctrl_in;
            Rd2Addr_IDEX  <= rt;
            WrR_IDEX      <= wr_sel;
            RegWrite_IDEX <= RegWrite & load_valid;
            MemWrite_IDEX <= MemWrite & load_valid;
            MemRead_IDEX  <= MemRead & load_valid;
            halt_IDEX     <= halt_IFID & load_valid;
            valid_IDEX    <= load_valid;
            if (load_valid && (size == IMM_BAD) && ctrl_in[ALUSRC_BIT]) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_p.sv
module tb_decode_stage_p;
    import decode_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_IFID, PC2_IFID, writeData;
    logic        valid_IFID, halt_IFID;
    logic [14:0] ctrl_in;
    logic [1:0]  RegDst, size;
    logic        zeroEx, RegWrite, MemWrite, MemRead, use_rs, use_rt;
    logic        stall_in, flush_in, RegWrite_MEMWB;
    logic [2:0]  WrR_MEMWB;
    logic [31:0] w_writeData;

    logic        stall_out;
    logic [15:0] PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
    logic [14:0] ctrl_IDEX;
    logic [2:0]  Rd2Addr_IDEX, WrR_IDEX;
    logic        RegWrite_IDEX, MemWrite_IDEX, MemRead_IDEX, halt_IDEX, valid_IDEX, err;

    // wide instance: NREG = 16, DATA_W = 32
    logic        w_stall_out, w_err, w_valid_IDEX, w_RegWrite_IDEX;
    logic [31:0] w_Rd1_IDEX, w_Imm_IDEX;
    logic [3:0]  w_WrR_IDEX;
    logic [31:0] w_pc2_unused, w_rd2_unused;
    logic [14:0] w_ctrl_unused;
    logic [3:0]  w_rd2addr_unused;
    logic        w_memwrite_unused, w_memread_unused, w_halt_unused;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage_p u_dut (
        .clk(clk), .rst(rst), .instr_IFID(instr_IFID), .PC2_IFID(PC2_IFID),
        .valid_IFID(valid_IFID), .halt_IFID(halt_IFID), .ctrl_in(ctrl_in),
        .RegDst(RegDst), .size(size), .zeroEx(zeroEx), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .use_rs(use_rs), .use_rt(use_rt),
        .stall_in(stall_in), .flush_in(flush_in), .RegWrite_MEMWB(RegWrite_MEMWB),
        .WrR_MEMWB(WrR_MEMWB), .writeData(writeData), .stall_out(stall_out),
        .PC2_IDEX(PC2_IDEX), .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX),
        .Imm_IDEX(Imm_IDEX), .ctrl_IDEX(ctrl_IDEX), .Rd2Addr_IDEX(Rd2Addr_IDEX),
        .WrR_IDEX(WrR_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
        .MemRead_IDEX(MemRead_IDEX), .halt_IDEX(halt_IDEX), .valid_IDEX(valid_IDEX),
        .err(err)
    );

    decode_stage_p #(.DATA_W(32), .NREG(16)) u_dut_w (
        .clk(clk), .rst(rst), .instr_IFID({16'h0, instr_IFID}), .PC2_IFID({16'h0, PC2_IFID}),
        .valid_IFID(valid_IFID), .halt_IFID(halt_IFID), .ctrl_in(ctrl_in),
        .RegDst(RegDst), .size(size), .zeroEx(zeroEx), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .use_rs(use_rs), .use_rt(use_rt),
        .stall_in(stall_in), .flush_in(flush_in), .RegWrite_MEMWB(RegWrite_MEMWB),
        .WrR_MEMWB({1'b0, WrR_MEMWB}), .writeData(w_writeData), .stall_out(w_stall_out),
        .PC2_IDEX(w_pc2_unused), .Rd1_IDEX(w_Rd1_IDEX), .Rd2_IDEX(w_rd2_unused),
        .Imm_IDEX(w_Imm_IDEX), .ctrl_IDEX(w_ctrl_unused), .Rd2Addr_IDEX(w_rd2addr_unused),
        .WrR_IDEX(w_WrR_IDEX), .RegWrite_IDEX(w_RegWrite_IDEX), .MemWrite_IDEX(w_memwrite_unused),
        .MemRead_IDEX(w_memread_unused), .halt_IDEX(w_halt_unused), .valid_IDEX(w_valid_IDEX),
        .err(w_err)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_IFID = '0; PC2_IFID = '0; valid_IFID = 0; halt_IFID = 0; ctrl_in = '0;
        RegDst = REGDST_RT; size = IMM5; zeroEx = 0; RegWrite = 0; MemWrite = 0;
        MemRead = 0; use_rs = 0; use_rt = 0; stall_in = 0; flush_in = 0;
        RegWrite_MEMWB = 0; WrR_MEMWB = '0; writeData = '0; w_writeData = '0;
    endtask

    // Puts a valid load writing R2 (rt field) into ID/EX.
    task automatic issue_load_r2();
        idle_inputs();
        instr_IFID = 16'h0040; valid_IFID = 1; MemRead = 1; RegWrite = 1; RegDst = REGDST_RT;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; idle_inputs();
        step(); step();
        checks++;
        if ({PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX, ctrl_IDEX, Rd2Addr_IDEX, WrR_IDEX,
             RegWrite_IDEX, MemWrite_IDEX, MemRead_IDEX, halt_IDEX, valid_IDEX} !== '0) begin
            errors++; $display("FAIL reset_outputs got pc2=%h rd1=%h imm=%h valid=%b expected all 0",
                               PC2_IDEX, Rd1_IDEX, Imm_IDEX, valid_IDEX);
        end
        checks++;
        if ({err, stall_out, w_err, w_valid_IDEX} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got err=%b stall=%b w_err=%b w_valid=%b expected 0",
                               err, stall_out, w_err, w_valid_IDEX);
        end
        rst = 0;
    endtask

    task automatic test_bypass();
        idle_inputs();
        instr_IFID = 16'h0300; valid_IFID = 1;              // rs = 3
        RegWrite_MEMWB = 1; WrR_MEMWB = 3'd3; writeData = 16'hBEEF; w_writeData = 32'hDEADBEEF;
        step();
        checks++;
        if (Rd1_IDEX !== 16'hBEEF) begin errors++; $display("FAIL bypass_rd1 got %h expected %h", Rd1_IDEX, 16'hBEEF); end
        checks++;
        if (w_Rd1_IDEX !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1_wide got %h expected %h", w_Rd1_IDEX, 32'hDEADBEEF); end
        checks++;
        if (valid_IDEX !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b expected 1", valid_IDEX); end
        // different write address must not bypass; R3 now comes from the file
        instr_IFID = 16'h0360; WrR_MEMWB = 3'd4; writeData = 16'h1111; w_writeData = 32'h11111111;
        step();
        checks++;
        if ({Rd1_IDEX, Rd2_IDEX} !== {16'hBEEF, 16'hBEEF}) begin
            errors++; $display("FAIL file_read got rd1=%h rd2=%h expected beef beef", Rd1_IDEX, Rd2_IDEX);
        end
        checks++;
        if (Rd2Addr_IDEX !== 3'd3) begin errors++; $display("FAIL rd2addr got %0d expected 3", Rd2Addr_IDEX); end
        checks++;
        if (w_Rd1_IDEX !== 32'hDEADBEEF) begin errors++; $display("FAIL file_read_wide got %h expected deadbeef", w_Rd1_IDEX); end
    endtask

    task automatic test_imm();
        idle_inputs();
        valid_IFID = 1; instr_IFID = 16'h0016; size = IMM5; zeroEx = 0;
        step();
        checks++;
        if (Imm_IDEX !== 16'hFFF6) begin errors++; $display("FAIL imm5_sext got %h expected fff6", Imm_IDEX); end
        checks++;
        if (w_Imm_IDEX !== 32'hFFFFFFF6) begin errors++; $display("FAIL imm5_sext_wide got %h expected fffffff6", w_Imm_IDEX); end
        zeroEx = 1;
        step();
        checks++;
        if (Imm_IDEX !== 16'h0016) begin errors++; $display("FAIL imm5_zext got %h expected 0016", Imm_IDEX); end
        zeroEx = 0; size = IMM11; instr_IFID = 16'h0400;
        step();
        checks++;
        if (Imm_IDEX !== 16'hFC00) begin errors++; $display("FAIL imm11_sext got %h expected fc00", Imm_IDEX); end
        checks++;
        if (w_Imm_IDEX !== 32'hFFFFFC00) begin errors++; $display("FAIL imm11_sext_wide got %h expected fffffc00", w_Imm_IDEX); end
        size = IMM8; instr_IFID = 16'h0080;
        step();
        checks++;
        if (Imm_IDEX !== 16'hFF80) begin errors++; $display("FAIL imm8_sext got %h expected ff80", Imm_IDEX); end
    endtask

    task automatic test_regdst();
        logic [1:0] sel_tab [4] = '{REGDST_RT, REGDST_RD, REGDST_RS, REGDST_R7};
        logic [2:0] exp_tab [4] = '{3'd6, 3'd3, 3'd5, 3'd7};
        logic [3:0] expw_tab [4] = '{4'd6, 4'd3, 4'd5, 4'd15};
        idle_inputs();
        valid_IFID = 1; instr_IFID = 16'h05CC;               // rs=5 rt=6 rd=3
        for (int i = 0; i < 4; i++) begin
            RegDst = sel_tab[i];
            step();
            checks++;
            if (WrR_IDEX !== exp_tab[i] || w_WrR_IDEX !== expw_tab[i]) begin
                errors++; $display("FAIL regdst_%0d got %0d/%0d expected %0d/%0d",
                                   i, WrR_IDEX, w_WrR_IDEX, exp_tab[i], expw_tab[i]);
            end
        end
    endtask

    task automatic test_load_use();
        issue_load_r2();
        instr_IFID = 16'h0050; MemRead = 0; RegWrite = 1; RegDst = REGDST_RD; use_rt = 1;  // rt=2 rd=4
        #1;
        checks++;
        if ({stall_out, w_stall_out} !== 2'b11) begin errors++; $display("FAIL hazard_stall got %b/%b expected 1/1", stall_out, w_stall_out); end
        step();
        checks++;
        if ({valid_IDEX, RegWrite_IDEX, MemRead_IDEX, w_valid_IDEX, w_RegWrite_IDEX} !== 5'b0) begin
            errors++; $display("FAIL hazard_bubble got valid=%b regwrite=%b memread=%b w_valid=%b expected 0",
                               valid_IDEX, RegWrite_IDEX, MemRead_IDEX, w_valid_IDEX);
        end
        checks++;
        if ({stall_out, w_stall_out} !== 2'b00) begin errors++; $display("FAIL hazard_release got %b/%b expected 0/0", stall_out, w_stall_out); end
        step();
        checks++;
        if ({valid_IDEX, RegWrite_IDEX, WrR_IDEX} !== {1'b1, 1'b1, 3'd4}) begin
            errors++; $display("FAIL hazard_issue got valid=%b regwrite=%b wrr=%0d expected 1 1 4",
                               valid_IDEX, RegWrite_IDEX, WrR_IDEX);
        end
        // rt matches but is not used: no stall
        issue_load_r2();
        instr_IFID = 16'h0040; MemRead = 0; use_rt = 0; use_rs = 0;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL hazard_unused_rt got %b expected 0", stall_out); end
        // rs path
        instr_IFID = 16'h0200; use_rs = 1;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin errors++; $display("FAIL hazard_rs got %b expected 1", stall_out); end
        step();
    endtask

    task automatic test_flush_beats_stall();
        issue_load_r2();
        instr_IFID = 16'h0050; MemRead = 0; use_rt = 1; stall_in = 1; flush_in = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall_out got %b expected 0", stall_out); end
        step();
        checks++;
        if ({valid_IDEX, RegWrite_IDEX, MemRead_IDEX} !== 3'b000) begin
            errors++; $display("FAIL flush_bubble got valid=%b regwrite=%b memread=%b expected 0 0 0",
                               valid_IDEX, RegWrite_IDEX, MemRead_IDEX);
        end
        // stall_in alone with a hazard: hold, no stall_out
        issue_load_r2();
        instr_IFID = 16'h0050; MemRead = 0; use_rt = 1; stall_in = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL stall_in_masks got %b expected 0", stall_out); end
        step();
        checks++;
        if ({valid_IDEX, MemRead_IDEX, WrR_IDEX} !== {1'b1, 1'b1, 3'd2}) begin
            errors++; $display("FAIL stall_in_hold_load got valid=%b memread=%b wrr=%0d expected 1 1 2",
                               valid_IDEX, MemRead_IDEX, WrR_IDEX);
        end
        stall_in = 0;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin errors++; $display("FAIL stall_after_hold got %b expected 1", stall_out); end
        step();
    endtask

    task automatic test_hold();
        idle_inputs();
        valid_IFID = 1; instr_IFID = 16'h0016; PC2_IFID = 16'h1234; ctrl_in = 15'h1AA5;
        RegDst = REGDST_RD; RegWrite = 1; halt_IFID = 0;
        step();
        stall_in = 1;
        for (int c = 0; c < 3; c++) begin
            instr_IFID = 16'($urandom_range(0, 16'hFFFF)); PC2_IFID = 16'($urandom_range(0, 16'hFFFF));
            ctrl_in = 15'($urandom_range(0, 15'h7FFF)); RegWrite = 0; MemWrite = 1; halt_IFID = 1;
            step();
            checks++;
            if ({PC2_IDEX, Imm_IDEX, ctrl_IDEX, WrR_IDEX, valid_IDEX, RegWrite_IDEX, MemWrite_IDEX, halt_IDEX}
                !== {16'h1234, 16'hFFF6, 15'h1AA5, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++; $display("FAIL hold_%0d got pc2=%h imm=%h ctrl=%h wrr=%0d v=%b rw=%b mw=%b h=%b expected 1234 fff6 1aa5 5 1 1 0 0",
                                   c, PC2_IDEX, Imm_IDEX, ctrl_IDEX, WrR_IDEX, valid_IDEX, RegWrite_IDEX, MemWrite_IDEX, halt_IDEX);
            end
        end
        stall_in = 0;
    endtask

    task automatic test_err_reset();
        idle_inputs();
        size = IMM_BAD; ctrl_in = 15'(1 << ALUSRC_BIT); instr_IFID = 16'h07FF; valid_IFID = 0;
        step();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_invalid got %b expected 0", err); end
        valid_IFID = 1;
        step();
        checks++;
        if ({Imm_IDEX, err, w_err} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++; $display("FAIL err_set got imm=%h err=%b w_err=%b expected 0000 1 1", Imm_IDEX, err, w_err);
        end
        idle_inputs(); valid_IFID = 1; instr_IFID = 16'h0016;
        step(); step();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", err); end
        rst = 1; stall_in = 1;
        step();
        checks++;
        if ({PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX, ctrl_IDEX, Rd2Addr_IDEX, WrR_IDEX, RegWrite_IDEX,
             MemWrite_IDEX, MemRead_IDEX, halt_IDEX, valid_IDEX, err, w_err} !== '0) begin
            errors++; $display("FAIL reset_midrun got imm=%h wrr=%0d valid=%b err=%b w_err=%b expected all 0",
                               Imm_IDEX, WrR_IDEX, valid_IDEX, err, w_err);
        end
        rst = 0; idle_inputs();
        valid_IFID = 1; instr_IFID = 16'h0360;                // read R3, was 0xBEEF
        step();
        checks++;
        if ({Rd1_IDEX, Rd2_IDEX, w_Rd1_IDEX} !== '0) begin
            errors++; $display("FAIL rf_cleared got %h %h %h expected 0", Rd1_IDEX, Rd2_IDEX, w_Rd1_IDEX);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_imm();
        test_regdst();
        test_load_use();
        test_flush_beats_stall();
        test_hold();
        test_err_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
